// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the instruction/data SRAM arbiter.
package mem_bus_pkg;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  localparam int unsigned MemSizeDefault  = 8192;
  localparam logic [31:0] MemStartDefault = 32'h0000_0000;

  // True when addr falls inside the window [start, start + mask].
  function automatic logic win_hit(input logic [31:0] addr,
                                   input logic [31:0] start,
                                   input logic [31:0] mask);
    return (addr & ~mask) == start;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Core-side instruction and data request/response ports of the SRAM arbiter.
interface mem_bus_arbiter_if;

  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic        instr_err_o;
  logic [31:0] instr_rdata_o;

  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_err_o;
  logic [31:0] data_rdata_o;

  // Core side drives requests.
  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o
  );

  // Arbiter side answers them.
  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o
  );

endinterface

// File: rtl/mem_bus_resp_trk.sv
// Tracks the single outstanding SRAM response and steers it to the owning port.
module mem_bus_resp_trk
  import mem_bus_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        gnt_i,
  input  owner_e      owner_i,
  input  logic        miss_i,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_rvalid_o,
  output logic        instr_err_o,
  output logic [31:0] instr_rdata_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  output logic [31:0] data_rdata_o
);

  logic   resp_valid_q, resp_valid_d;
  owner_e resp_owner_q, resp_owner_d;
  logic   resp_err_q,   resp_err_d;

  always_comb begin
    resp_valid_d = gnt_i;
    resp_owner_d = resp_owner_q;
    resp_err_d   = 1'b0;
    if (gnt_i) begin
      resp_owner_d = owner_i;
      resp_err_d   = miss_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= OWN_INSTR;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
      resp_err_q   <= resp_err_d;
    end
  end

  logic        resp_instr, resp_data;
  logic [31:0] resp_rdata;

  always_comb begin
    resp_instr = resp_valid_q && (resp_owner_q == OWN_INSTR);
    resp_data  = resp_valid_q && (resp_owner_q == OWN_DATA);
    // Error responses never leak SRAM data.
    resp_rdata = (resp_valid_q && !resp_err_q) ? mem_rdata_i : 32'h0;

    instr_rvalid_o = resp_instr;
    instr_err_o    = resp_instr & resp_err_q;
    instr_rdata_o  = resp_instr ? resp_rdata : 32'h0;
    data_rvalid_o  = resp_data;
    data_err_o     = resp_data & resp_err_q;
    data_rdata_o   = resp_data ? resp_rdata : 32'h0;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates ibex instruction and data ports onto one single-port SRAM.
// Define MEM_ARB_FAIR_EN for round-robin; default is fixed instruction priority.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned MEM_SIZE  = MemSizeDefault,
  parameter logic [31:0] MEM_START = MemStartDefault
) (
  input  logic               clk_sys,
  input  logic               rst_sys,
  mem_bus_arbiter_if.slave   bus,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [3:0]         mem_be_o,
  output logic [31:0]        mem_addr_o,
  output logic [31:0]        mem_wdata_o,
  input  logic [31:0]        mem_rdata_i
);

  localparam logic [31:0] MEM_MASK = 32'(MEM_SIZE - 1);

  logic        prefer_instr;
  logic        instr_wins, data_wins, gnt_any;
  logic [31:0] win_addr;
  logic        hit;
  owner_e      win_owner;

`ifdef MEM_ARB_FAIR_EN
  owner_e last_winner_q, last_winner_d;

  always_comb begin
    last_winner_d = last_winner_q;
    if (gnt_any) last_winner_d = win_owner;
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) last_winner_q <= OWN_DATA;
    else         last_winner_q <= last_winner_d;
  end

  assign prefer_instr = (last_winner_q == OWN_DATA);
`else
  assign prefer_instr = 1'b1;
`endif

  // Grants are suppressed while reset is held so nothing is accepted and then dropped.
  always_comb begin
    instr_wins = !rst_sys && bus.instr_req_i && (!bus.data_req_i || prefer_instr);
    data_wins  = !rst_sys && bus.data_req_i && !instr_wins;
    gnt_any    = instr_wins || data_wins;
    win_owner  = instr_wins ? OWN_INSTR : OWN_DATA;
    win_addr   = instr_wins ? bus.instr_addr_i : bus.data_addr_i;
    hit        = win_hit(win_addr, MEM_START, MEM_MASK);
  end

  assign bus.instr_gnt_o = instr_wins;
  assign bus.data_gnt_o  = data_wins;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (gnt_any && hit) begin
      mem_req_o  = 1'b1;
      mem_addr_o = win_addr;
      if (instr_wins) begin
        mem_be_o = 4'hF;
      end else begin
        mem_we_o    = bus.data_we_i;
        mem_be_o    = bus.data_be_i;
        mem_wdata_o = bus.data_wdata_i;
      end
    end
  end

  mem_bus_resp_trk u_resp_trk (
    .clk_i          (clk_sys),
    .rst_i          (rst_sys),
    .gnt_i          (gnt_any),
    .owner_i        (win_owner),
    .miss_i         (!hit),
    .mem_rdata_i    (mem_rdata_i),
    .instr_rvalid_o (bus.instr_rvalid_o),
    .instr_err_o    (bus.instr_err_o),
    .instr_rdata_o  (bus.instr_rdata_o),
    .data_rvalid_o  (bus.data_rvalid_o),
    .data_err_o     (bus.data_err_o),
    .data_rdata_o   (bus.data_rdata_o)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural 1-cycle-latency SRAM.
module tb_mem_bus_arbiter;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter u_dut (
    .clk_sys     (clk_sys),
    .rst_sys     (rst_sys),
    .bus         (bus.slave),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_be_o    (mem_be),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk_sys = ~clk_sys;

  // SRAM model: word i preloads to 0xA500_0000 | i on every reset.
  logic [31:0] ram_q [2048];
  always @(posedge clk_sys) begin
    if (rst_sys) begin
      for (int i = 0; i < 2048; i++) ram_q[i] <= 32'hA500_0000 | 32'(i);
      mem_rdata <= 32'h0;
    end else if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram_q[mem_addr[12:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= ram_q[mem_addr[12:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle_inputs();
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = 32'h0;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = 4'h0;
    bus.data_addr_i  = 32'h0;
    bus.data_wdata_i = 32'h0;
  endtask

  task automatic run_contention(input string tag);
    next_cycle();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h80;
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = 4'hF;
    bus.data_addr_i  = 32'h100;
    @(negedge clk_sys);
    check({tag, "_ignt0"}, 32'(bus.instr_gnt_o), 32'd1);
    check({tag, "_dgnt0"}, 32'(bus.data_gnt_o), 32'd0);
    check({tag, "_maddr0"}, mem_addr, 32'h80);
    check({tag, "_mbe0"}, 32'(mem_be), 32'hF);
    next_cycle();
    bus.instr_req_i = 1'b0;
    @(negedge clk_sys);
    check({tag, "_irvalid"}, 32'(bus.instr_rvalid_o), 32'd1);
    check({tag, "_irdata"}, bus.instr_rdata_o, 32'hA500_0020);
    check({tag, "_dgnt1"}, 32'(bus.data_gnt_o), 32'd1);
    check({tag, "_drvalid1"}, 32'(bus.data_rvalid_o), 32'd0);
    next_cycle();
    bus.data_req_i = 1'b0;
    @(negedge clk_sys);
    check({tag, "_drvalid"}, 32'(bus.data_rvalid_o), 32'd1);
    check({tag, "_drdata"}, bus.data_rdata_o, 32'hA500_0040);
    check({tag, "_irvalid2"}, 32'(bus.instr_rvalid_o), 32'd0);
  endtask

  initial begin
    // Reset with both requests asserted.
    rst_sys = 1'b1;
    idle_inputs();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h80;
    bus.data_req_i   = 1'b1;
    bus.data_addr_i  = 32'h100;
    repeat (2) @(negedge clk_sys);
    check("rst_ignt", 32'(bus.instr_gnt_o), 32'd0);
    check("rst_dgnt", 32'(bus.data_gnt_o), 32'd0);
    check("rst_mreq", 32'(mem_req), 32'd0);
    check("rst_irvalid", 32'(bus.instr_rvalid_o), 32'd0);
    check("rst_drvalid", 32'(bus.data_rvalid_o), 32'd0);
    check("rst_errs", {30'd0, bus.instr_err_o, bus.data_err_o}, 32'd0);
    check("rst_maddr", mem_addr, 32'h0);
    next_cycle();
    rst_sys = 1'b0;
    idle_inputs();

    run_contention("cont");

    // Window miss: 0x4000 is outside an 8 KiB window at 0.
    next_cycle();
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b1;
    bus.data_be_i    = 4'hF;
    bus.data_addr_i  = 32'h4000;
    bus.data_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk_sys);
    check("miss_dgnt", 32'(bus.data_gnt_o), 32'd1);
    check("miss_mreq", 32'(mem_req), 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk_sys);
    check("miss_rvalid", 32'(bus.data_rvalid_o), 32'd1);
    check("miss_err", 32'(bus.data_err_o), 32'd1);
    check("miss_rdata", bus.data_rdata_o, 32'h0);

    // Partial store hit, then read it back.
    next_cycle();
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b1;
    bus.data_be_i    = 4'b0011;
    bus.data_addr_i  = 32'h200;
    bus.data_wdata_i = 32'h1234_5678;
    @(negedge clk_sys);
    check("st_mreq", 32'(mem_req), 32'd1);
    check("st_mwe", 32'(mem_we), 32'd1);
    check("st_mbe", 32'(mem_be), 32'h3);
    check("st_mwdata", mem_wdata, 32'h1234_5678);
    next_cycle();
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = 4'hF;
    bus.data_wdata_i = 32'h0;
    @(negedge clk_sys);
    check("st_rvalid", 32'(bus.data_rvalid_o), 32'd1);
    check("st_err", 32'(bus.data_err_o), 32'd0);
    check("ld_gnt", 32'(bus.data_gnt_o), 32'd1);
    next_cycle();
    idle_inputs();
    @(negedge clk_sys);
    check("ld_rdata", bus.data_rdata_o, 32'hA500_5678);

    // Back-to-back fetches.
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      bus.instr_req_i  = (i < 3);
      bus.instr_addr_i = (i < 3) ? 32'h80 + 32'(4 * i) : 32'h0;
      @(negedge clk_sys);
      if (i < 3) check($sformatf("b2b_gnt%0d", i), 32'(bus.instr_gnt_o), 32'd1);
      if (i > 0) begin
        check($sformatf("b2b_rv%0d", i), 32'(bus.instr_rvalid_o), 32'd1);
        check($sformatf("b2b_rd%0d", i), bus.instr_rdata_o, 32'hA500_0020 + 32'(i - 1));
      end
    end

    // Reset the cycle after a data grant: the pending response is dropped.
    next_cycle();
    bus.data_req_i  = 1'b1;
    bus.data_be_i   = 4'hF;
    bus.data_addr_i = 32'h100;
    @(negedge clk_sys);
    check("mid_dgnt", 32'(bus.data_gnt_o), 32'd1);
    next_cycle();
    idle_inputs();
    rst_sys = 1'b1;
    @(negedge clk_sys);
    check("mid_rvalid0", 32'(bus.data_rvalid_o), 32'd0);
    next_cycle();
    @(negedge clk_sys);
    check("mid_rvalid1", 32'(bus.data_rvalid_o), 32'd0);
    next_cycle();
    rst_sys = 1'b0;
    @(negedge clk_sys);
    check("mid_rvalid2", 32'(bus.data_rvalid_o), 32'd0);
    run_contention("post");

    // Sustained contention for six cycles; last grant above went to data.
    next_cycle();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h80;
    bus.data_req_i   = 1'b1;
    bus.data_be_i    = 4'hF;
    bus.data_addr_i  = 32'h100;
    for (int i = 0; i < 6; i++) begin
      logic exp_i;
`ifdef MEM_ARB_FAIR_EN
      exp_i = (i % 2 == 0);
`else
      exp_i = 1'b1;
`endif
      @(negedge clk_sys);
      check($sformatf("rr_ignt%0d", i), 32'(bus.instr_gnt_o), 32'(exp_i));
      check($sformatf("rr_dgnt%0d", i), 32'(bus.data_gnt_o), 32'(!exp_i));
      next_cycle();
    end
    idle_inputs();
    repeat (2) next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
